// File: rtl/ifu_fetch.sv
// ifu_fetch: fetch-stage PC register, AdEL fetch check and IF/ID pipeline register.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_LO      = 32'h0000_3000,
    parameter logic [31:0] IM_HI      = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        stall,
    input  logic        req,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        F_bd,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] i_inst_addr,
    output logic [31:0] F_pc,
    output logic [31:0] D_pc,
    output logic [31:0] D_instr,
    output logic [4:0]  D_exccode,
    output logic        D_bd,
    output logic [31:0] fetch_cnt
);
    logic [31:0] pc;
    logic [4:0]  f_exc;
    assign F_pc        = pc;
    assign i_inst_addr = pc;
    always_comb f_exc = (pc[1:0] != 2'b00 || pc < IM_LO || pc > IM_HI) ? 5'd4 : 5'd0;
    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_PC;
            D_pc      <= 32'h0;
            D_instr   <= 32'h0;
            D_exccode <= 5'd0;
            D_bd      <= 1'b0;
            fetch_cnt <= 32'h0;
        end else if (req) begin
            pc        <= HANDLER_PC;
            D_pc      <= HANDLER_PC;
            D_instr   <= 32'h0;
            D_exccode <= 5'd0;
            D_bd      <= 1'b0;
        end else if (!stall) begin
            // eret redirects without a delay slot, so D gets a bubble
            if (eret) begin
                pc        <= epc;
                D_pc      <= epc;
                D_instr   <= 32'h0;
                D_exccode <= 5'd0;
                D_bd      <= 1'b0;
            end else begin
                pc        <= npc;
                D_pc      <= pc;
                D_instr   <= (f_exc != 5'd0) ? 32'h0 : i_inst_rdata;
                D_exccode <= f_exc;
                D_bd      <= F_bd;
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end
endmodule
